// File: rtl/scan_code_sequencer.sv
// PS/2 set-2 scan-code sequencer: byte strobe, E0/F0 prefix collapse, event FIFO.
// Ports: FCLK/RST_N, CODE_VALID/SCAN_CODE in, EVT_* head + FIFO_LEVEL/OVERFLOW out. Macro: SCAN_EXT_EN.
module scan_code_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     FCLK,
  input  logic                     RST_N,
  input  logic                     CODE_VALID,
  input  logic [7:0]               SCAN_CODE,
  input  logic                     EVT_READY,
  input  logic                     OVF_CLR,
  output logic                     EVT_VALID,
  output logic [7:0]               EVT_CODE,
  output logic                     EVT_BREAK,
  output logic                     EVT_EXT,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output logic                     OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
`ifdef SCAN_EXT_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

`ifdef SCAN_EXT_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_F0   = 2'd1,
    PRE_E0   = 2'd2,
    PRE_E0F0 = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRE_F0 = 2'd1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic            prev_q;
  logic [CW-1:0]   cnt_q;
  logic            take, is_f0;
  logic            push_req, push_ext, push_brk;
  logic [9:0]      din;

  assign take  = CODE_VALID & ~prev_q
               & (SCAN_CODE != 8'h00);
  assign is_f0 = SCAN_CODE == 8'hF0;
`ifdef SCAN_EXT_EN
  logic is_e0;
  assign is_e0 = SCAN_CODE == 8'hE0;
`endif

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    push_ext = 1'b0;
    push_brk = 1'b0;
    if (take) begin
      unique case (state_q)
        IDLE: begin
          if (is_f0) state_d = PRE_F0;
`ifdef SCAN_EXT_EN
          else if (is_e0) state_d = PRE_E0;
`endif
          else push_req = 1'b1;
        end
        PRE_F0: begin
          if (is_f0) state_d = PRE_F0;
`ifdef SCAN_EXT_EN
          else if (is_e0) state_d = PRE_E0F0;
`endif
          else begin
            push_req = 1'b1;
            push_brk = 1'b1;
            state_d  = IDLE;
          end
        end
`ifdef SCAN_EXT_EN
        PRE_E0: begin
          if (is_f0) state_d = PRE_E0F0;
          else if (is_e0) state_d = PRE_E0;
          else begin
            push_req = 1'b1;
            push_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        PRE_E0F0: begin
          if (is_f0 || is_e0) state_d = PRE_E0F0;
          else begin
            push_req = 1'b1;
            push_ext = 1'b1;
            push_brk = 1'b1;
            state_d  = IDLE;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE
                 && cnt_q == TO_MAX) begin
      // stale prefix: drop it silently
      state_d = IDLE;
    end
  end

  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= CODE_VALID;
      if (take || state_q == IDLE
          || cnt_q == TO_MAX)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);
    end
  end

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [9:0]    head_q, head_d;
  logic          full, pop, push;

  assign din  = {push_ext, push_brk, SCAN_CODE};
  assign full = lvl_q == FULL_LVL;
  assign pop  = (lvl_q != '0) & EVT_READY;
  assign push = push_req & (~full | pop);
  assign rd_d = pop ? rd_q + AW'(1) : rd_q;
  assign lvl_d = lvl_q + LW'(push) - LW'(pop);

  // Head register tracks the entry at the next read pointer; when that
  // slot is being written this cycle the incoming word is forwarded.
  always_comb begin
    head_d = head_q;
    if (lvl_d != '0) begin
      if (push && rd_d == wr_q) head_d = din;
      else head_d = mem[rd_d];
    end
  end

  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      head_q   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_q] <= din;
        wr_q      <= wr_q + AW'(1);
      end
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      head_q <= head_d;
      if (push_req && full && !pop)
        OVERFLOW <= 1'b1;
      else if (OVF_CLR)
        OVERFLOW <= 1'b0;
    end
  end

  assign EVT_VALID  = lvl_q != '0;
  assign EVT_CODE   = head_q[7:0];
  assign EVT_BREAK  = head_q[8];
  assign EVT_EXT    = head_q[9] & EXT_EN;
  assign FIFO_LEVEL = lvl_q;

endmodule

// File: tb/tb_scan_code_sequencer.sv
// Self-checking bench for scan_code_sequencer: vector table, corner sequences,
// and randomized traffic against an event-level reference model.
module tb_scan_code_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1024;
  localparam int LW      = $clog2(DEPTH) + 1;
`ifdef SCAN_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic          FCLK = 1'b0;
  logic          RST_N;
  logic          CODE_VALID;
  logic [7:0]    SCAN_CODE;
  logic          EVT_READY;
  logic          OVF_CLR;
  logic          EVT_VALID;
  logic [7:0]    EVT_CODE;
  logic          EVT_BREAK;
  logic          EVT_EXT;
  logic [LW-1:0] FIFO_LEVEL;
  logic          OVERFLOW;

  scan_code_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .FCLK(FCLK), .RST_N(RST_N),
    .CODE_VALID(CODE_VALID), .SCAN_CODE(SCAN_CODE),
    .EVT_READY(EVT_READY), .OVF_CLR(OVF_CLR),
    .EVT_VALID(EVT_VALID), .EVT_CODE(EVT_CODE),
    .EVT_BREAK(EVT_BREAK), .EVT_EXT(EVT_EXT),
    .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 FCLK = ~FCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: stream decoder with prefix flags and an event queue.
  bit         m_prev, m_ext, m_brk, m_ovf;
  int         m_last, cyc;
  logic [9:0] mq[$];

  task automatic model_reset();
    m_prev = 0; m_ext = 0; m_brk = 0; m_ovf = 0;
    mq.delete();
  endtask

  task automatic model_step(bit cv, logic [7:0] code,
                            bit rdy, bit clr);
    bit ev, pop;
    logic [9:0] e;
    int n;
    ev = 0; e = '0;
    if (cv && !m_prev && code != 8'h00) begin
      if ((m_ext || m_brk) && cyc - m_last > TIMEOUT) begin
        m_ext = 0; m_brk = 0;
      end
      m_last = cyc;
      if (code == 8'hF0) m_brk = 1;
      else if (EXT && code == 8'hE0) m_ext = 1;
      else begin
        ev = 1; e = {m_ext, m_brk, code};
        m_ext = 0; m_brk = 0;
      end
    end
    m_prev = cv;
    n   = mq.size();
    pop = n > 0 && rdy;
    if (pop) void'(mq.pop_front());
    if (ev && (n < DEPTH || pop)) mq.push_back(e);
    if (ev && n == DEPTH && !pop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    cyc++;
  endtask

  task automatic mcheck();
    chk("m_valid", int'(EVT_VALID), int'(mq.size() != 0));
    chk("m_level", int'(FIFO_LEVEL), mq.size());
    chk("m_ovf", int'(OVERFLOW), int'(m_ovf));
    if (mq.size() != 0)
      chk("m_head", int'({EVT_EXT, EVT_BREAK, EVT_CODE}),
          int'(mq[0]));
  endtask

  // Inputs change at the falling edge; outputs are read at the next one.
  task automatic tick(bit cv, logic [7:0] code,
                      bit rdy, bit clr);
    CODE_VALID = cv; SCAN_CODE = code;
    EVT_READY = rdy; OVF_CLR = clr;
    model_step(cv, code, rdy, clr);
    @(posedge FCLK);
    @(negedge FCLK);
    mcheck();
  endtask

  task automatic send(logic [7:0] b, bit rdy);
    tick(1, b, rdy, 0);
    tick(0, b, rdy, 0);
  endtask

  task automatic head(string nm, logic [9:0] exp);
    chk({nm, "_v"}, int'(EVT_VALID), 1);
    chk(nm, int'({EVT_EXT, EVT_BREAK, EVT_CODE}), int'(exp));
  endtask

  typedef struct {
    bit cv; logic [7:0] code; bit rdy; bit clr;
    bit v; logic [7:0] ec; bit eb; bit ee;
    int lvl; bit ovf;
  } vec_t;

  function automatic vec_t mk(bit cv, logic [7:0] code,
      bit rdy, bit clr, bit v, logic [7:0] ec,
      bit eb, bit ee, int lvl, bit ovf);
    vec_t t;
    t.cv = cv; t.code = code; t.rdy = rdy; t.clr = clr;
    t.v = v; t.ec = ec; t.eb = eb; t.ee = ee;
    t.lvl = lvl; t.ovf = ovf;
    return t;
  endfunction

  vec_t vt[16];

  initial begin
    logic [7:0] exp_q[$];
    RST_N = 0; CODE_VALID = 0; SCAN_CODE = 0;
    EVT_READY = 0; OVF_CLR = 0;
    cyc = 0; m_last = 0;
    model_reset();
    repeat (2) @(negedge FCLK);
    chk("rst_valid", int'(EVT_VALID), 0);
    chk("rst_code", int'(EVT_CODE), 0);
    chk("rst_brk", int'(EVT_BREAK), 0);
    chk("rst_ext", int'(EVT_EXT), 0);
    chk("rst_level", int'(FIFO_LEVEL), 0);
    chk("rst_ovf", int'(OVERFLOW), 0);
    RST_N = 1;

    for (int i = 0; i < 5; i++)
      vt[i] = mk(1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1, 0);
    vt[5]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[6]  = mk(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[7]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[8]  = mk(1, 8'h1C, 0, 0, 1, 8'h1C, 1, 0, 1, 0);
    vt[9]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
`ifdef SCAN_EXT_EN
    vt[10] = mk(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[11] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[14] = mk(1, 8'h75, 0, 0, 1, 8'h75, 1, 1, 1, 0);
`else
    vt[10] = mk(1, 8'hE0, 0, 0, 1, 8'hE0, 0, 0, 1, 0);
    vt[11] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[14] = mk(1, 8'h75, 0, 0, 1, 8'h75, 1, 0, 1, 0);
`endif
    vt[12] = mk(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[13] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    vt[15] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);

    foreach (vt[i]) begin
      tick(vt[i].cv, vt[i].code, vt[i].rdy, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), int'(EVT_VALID),
          int'(vt[i].v));
      chk($sformatf("vec%0d_level", i), int'(FIFO_LEVEL),
          vt[i].lvl);
      chk($sformatf("vec%0d_ovf", i), int'(OVERFLOW),
          int'(vt[i].ovf));
      if (vt[i].v)
        chk($sformatf("vec%0d_head", i),
            int'({EVT_EXT, EVT_BREAK, EVT_CODE}),
            int'({vt[i].ee, vt[i].eb, vt[i].ec}));
    end

    // prefix timeout: full window expires, one cycle short does not
    send(8'hF0, 1);
    repeat (TIMEOUT) tick(0, 0, 1, 0);
    tick(1, 8'h1C, 0, 0);
    head("to_expired", {2'b00, 8'h1C});
    tick(0, 0, 1, 0);
    send(8'hF0, 1);
    repeat (TIMEOUT - 2) tick(0, 0, 1, 0);
    tick(1, 8'h1C, 0, 0);
    head("to_edge", {2'b01, 8'h1C});
    tick(0, 0, 1, 0);

    // overflow: DEPTH+1 codes with the consumer stalled
    for (int i = 1; i <= DEPTH + 1; i++)
      send(8'(i), 0);
    chk("ovf_level", int'(FIFO_LEVEL), DEPTH);
    chk("ovf_set", int'(OVERFLOW), 1);
    for (int i = 1; i <= DEPTH; i++) begin
      head($sformatf("ovf_drain%0d", i), {2'b00, 8'(i)});
      tick(0, 0, 1, 0);
    end
    chk("ovf_empty", int'(EVT_VALID), 0);
    chk("ovf_sticky", int'(OVERFLOW), 1);
    tick(0, 0, 0, 1);
    chk("ovf_clr", int'(OVERFLOW), 0);

    // full FIFO: push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++)
      send(8'h11 + 8'(i), 0);
    tick(1, 8'h11 + 8'(DEPTH), 1, 0);
    chk("fp_level", int'(FIFO_LEVEL), DEPTH);
    chk("fp_ovf", int'(OVERFLOW), 0);
    for (int i = 1; i <= DEPTH; i++)
      exp_q.push_back(8'h11 + 8'(i));
    foreach (exp_q[i]) begin
      head($sformatf("fp_drain%0d", i), {2'b00, exp_q[i]});
      tick(0, 0, 1, 0);
    end
    chk("fp_empty", int'(EVT_VALID), 0);

    // reset mid-prefix with events queued
    send(8'h21, 0);
    send(8'h22, 0);
    send(EXT ? 8'hE0 : 8'hF0, 0);
    chk("pre_level", int'(FIFO_LEVEL), 2);
    RST_N = 0;
    CODE_VALID = 1; SCAN_CODE = 8'h1C;
    #1;
    chk("rst2_valid", int'(EVT_VALID), 0);
    chk("rst2_code", int'(EVT_CODE), 0);
    chk("rst2_brk", int'(EVT_BREAK), 0);
    chk("rst2_ext", int'(EVT_EXT), 0);
    chk("rst2_level", int'(FIFO_LEVEL), 0);
    chk("rst2_ovf", int'(OVERFLOW), 0);
    model_reset();
    @(negedge FCLK);
    RST_N = 1;
    tick(1, 8'h1C, 0, 0);
    head("rst2_first", {2'b00, 8'h1C});
    chk("rst2_lvl1", int'(FIFO_LEVEL), 1);
    tick(0, 0, 1, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) c = 8'h00;
      else if (r < 3) c = 8'hE0;
      else if (r < 5) c = 8'hF0;
      else c = 8'($urandom);
      tick(bit'($urandom_range(0, 1)), c,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/scan_code_sequencer.md
# scan_code_sequencer

Sequencing stage between the scan-code validity checker and any consumer of keyboard events (LED driver, host interface). Detects each new validated scan-code byte, collapses PS/2 set-2 prefix bytes (E0 extended, F0 break) into single make/break events, and buffers events in a small FIFO drained by a valid/ready handshake. Runs entirely on the fast clock; the byte source is already synchronised to it.

## Interface
- DEPTH, 4: FIFO depth in events; power of two, 2..16.
- TIMEOUT, 1024: FCLK cycles a prefix may wait for its follow-up byte before it is discarded; must be ≥ 2.

- FCLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CODE_VALID  input  1  level; high while SCAN_CODE holds a validated byte; may stay high for many cycles.
- SCAN_CODE  input  8  byte from the receiver; sampled only on a CODE_VALID rising edge.
- EVT_READY  input  1  consumer accepts the head event this cycle.
- OVF_CLR  input  1  synchronous clear of OVERFLOW.
- EVT_VALID  output  1  FIFO non-empty.
- EVT_CODE  output  8  key code of head event.
- EVT_BREAK  output  1  head event is a release.
- EVT_EXT  output  1  head event had an E0 prefix.
- FIFO_LEVEL  output  $clog2(DEPTH)+1  events stored.
- OVERFLOW  output  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Byte strobe: internal register holds previous CODE_VALID; a byte is taken in any cycle where CODE_VALID=1 and previous=0. Holding CODE_VALID high yields exactly one byte.
- Byte 0x00 is ignored (no state change, no event).
- Prefix FSM states IDLE, PRE_E0, PRE_F0, PRE_E0F0. On a taken byte:
  - IDLE: E0 → PRE_E0; F0 → PRE_F0; other → push {ext=0,brk=0,code}.
  - PRE_E0: F0 → PRE_E0F0; E0 → stay; other → push {1,0,code}, → IDLE.
  - PRE_F0: F0 → stay; E0 → PRE_E0F0; other → push {0,1,code}, → IDLE.
  - PRE_E0F0: E0/F0 → stay; other → push {1,1,code}, → IDLE.
- Timeout counter: cleared on every taken byte; increments each cycle while state ≠ IDLE; on reaching TIMEOUT−1 the FSM returns to IDLE, nothing pushed. Counter held at 0 in IDLE.
- FIFO: circular buffer, 10-bit entries {ext,brk,code}; pointers $clog2(DEPTH) bits, wrap naturally. Pop when EVT_VALID && EVT_READY.
- Full: push with no pop is dropped, OVERFLOW←1. Push and pop in the same cycle when full: both performed, no overflow. Push and pop when empty: push only (no bypass).
- OVERFLOW set has priority over OVF_CLR in the same cycle.

## Timing
- Reset (async assert, sync-released by the system): FSM IDLE, counters 0, previous CODE_VALID 0, EVT_VALID 0, EVT_CODE 0x00, EVT_BREAK 0, EVT_EXT 0, FIFO_LEVEL 0, OVERFLOW 0. Reset mid-prefix or with FIFO contents discards everything.
- CODE_VALID high at reset release counts as a rising edge on the first clock.
- Latency: final byte taken in cycle N → EVT_VALID and head fields valid in cycle N+1 (FIFO previously empty).
- Head fields are registered FIFO read data; stable while EVT_VALID && !EVT_READY.
- FIFO_LEVEL updates the cycle after push/pop; throughput one event per cycle.

## Configuration
- SCAN_EXT_EN defined: E0 handled as above; EVT_EXT reflects prefix.
- Not defined: PRE_E0 and PRE_E0F0 removed; E0 treated as an ordinary code byte (IDLE pushes {0,0,E0}; PRE_F0 pushes {0,1,E0}); EVT_EXT tied 0.

## Test plan
- Reset, CODE_VALID pulses 0x1C held 5 cycles → single event {ext0,brk0,0x1C}, EVT_VALID next cycle, FIFO_LEVEL=1.
- Bytes F0,1C then E0,F0,75 with EVT_READY=1 → events {0,1,0x1C} then {1,1,0x75}; with SCAN_EXT_EN off → {0,0,E0},{0,1,0x75} for the second sequence.
- Byte F0 then TIMEOUT idle cycles, then 0x1C → single make event {0,0,0x1C}.
- EVT_READY=0, DEPTH+1 codes 0x01..0x05 (DEPTH=4) → FIFO_LEVEL=4, OVERFLOW=1, drained order 0x01..0x04; OVF_CLR → OVERFLOW=0.
- FIFO full, new byte taken in same cycle as pop → no overflow, FIFO_LEVEL stays 4, new code last out.
- RST_N asserted while in PRE_E0 with 2 events queued → all outputs at reset values; following 0x1C gives {0,0,0x1C}.
